uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of payload bits per frame (legal range 1..16).
REQ-002 CLK  input  1  transmit bit clock; one serial bit per CLK cycle; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 P_DATA  input  DATA_WIDTH  parallel payload; sampled only on the accept edge.
REQ-005 Data_Valid  input  1  request to transmit P_DATA; synchronous.
REQ-006 PAR_EN  input  1  parity enable; sampled only on the accept edge.
REQ-007 Par_Bit  input  1  parity bit from the parity calculator; sampled only in the PARITY state.
REQ-008 TX_OUT  output  1  serial line, registered; idle level 1.
REQ-009 Busy  output  1  frame in progress, registered; also feeds the parity calculator BUSY input.

Function
REQ-010 States: IDLE, START, DATA, PARITY, STOP; state, shift register, bit counter, latched PAR_EN, TX_OUT and Busy are all registers.
REQ-011 Accept: in IDLE, a rising edge with Data_Valid=1 loads P_DATA into the shift register, latches PAR_EN, clears the bit counter, and moves to START.
REQ-012 Data_Valid while Busy=1 is ignored; P_DATA/PAR_EN changes after accept do not affect the frame in progress.
REQ-013 START: TX_OUT=0 for exactly 1 cycle, then DATA.
REQ-014 DATA: TX_OUT = payload bit[k] for k = 0..DATA_WIDTH-1, LSB first, one cycle each; the bit counter increments per cycle; when it reaches DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
REQ-015 PARITY: TX_OUT = Par_Bit for exactly 1 cycle, then STOP; the block performs no parity computation of its own.
REQ-016 STOP: TX_OUT=1 for exactly 1 cycle, then IDLE.
REQ-017 Busy=1 from the cycle after the accept edge through the last STOP cycle inclusive; Busy=0 in IDLE.
REQ-018 Frame length in Busy=1 cycles = DATA_WIDTH+2 (PAR_EN=0) or DATA_WIDTH+3 (PAR_EN=1).
REQ-019 Back-to-back: the earliest next accept is the edge ending the first IDLE cycle after STOP; the minimum inter-frame gap is 1 idle cycle with TX_OUT=1.
REQ-020 TX_OUT=1 in IDLE at all times, including while Data_Valid=1 before the accept edge.
REQ-021 The bit counter is wide enough for DATA_WIDTH-1 and never wraps within a frame; it is cleared on every accept.
REQ-022 Illegal or unreachable state encodings return to IDLE on the next edge with TX_OUT=1 and Busy=0.
REQ-023 Par_Bit is valid no later than 2 cycles after the accept edge; the block relies on this (latency DATA_WIDTH+1 ≥ 2 for all legal widths).

Reset
REQ-024 RST=0 forces, asynchronously, state=IDLE, TX_OUT=1, Busy=0, shift register=0, bit counter=0, latched PAR_EN=0.
REQ-025 Reset mid-frame aborts the frame immediately; after release, the block sits in IDLE and the first accept starts a complete new frame.
REQ-026 Data_Valid high on the first edge after reset release is accepted normally.

Verification
REQ-027 DATA_WIDTH=8, PAR_EN=1, even parity, P_DATA=0xA5, 1-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (11 cycles), Busy=1 for exactly those 11 cycles.
REQ-028 PAR_EN=0, P_DATA=0x3C -> TX_OUT 0,0,0,1,1,1,1,0,0,1 (10 cycles); no parity cycle.
REQ-029 PAR_EN=1, odd parity, P_DATA=0x01 -> TX_OUT 0,1,0,0,0,0,0,0,0,0,1; parity bit = 0.
REQ-030 Data_Valid held high continuously with P_DATA changing to 0xFF mid-frame -> current frame unchanged; next frame (0xFF) starts after exactly 1 idle cycle.
REQ-031 RST pulsed low during DATA bit 4 -> TX_OUT=1 and Busy=0 immediately; a frame for 0x55 after release is complete and correct.
REQ-032 Parity calculator connected, random P_DATA/PAR_TYP/PAR_EN over 1000 frames -> a scoreboard decoding TX_OUT matches the payload and expected parity on every frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Serial frame transmitter. Each CLK cycle carries one serial bit. A frame is
// a start bit (0), DATA_WIDTH payload bits LSB first, an optional parity bit
// supplied by an external parity calculator, and a stop bit (1).
//
// Parameters
//   DATA_WIDTH  payload bits per frame, 1..16
//
// Ports
//   CLK         bit clock, rising edge active
//   RST         asynchronous, active-low reset
//   P_DATA      parallel payload, captured on the accept edge
//   Data_Valid  transmit request, only honoured while idle
//   PAR_EN      parity enable, captured on the accept edge
//   Par_Bit     parity bit from the external parity calculator
//   TX_OUT      registered serial line, idles high
//   Busy        registered frame-in-progress flag (also drives the parity
//               calculator's BUSY input)
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  Par_Bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    // Counter only has to reach DATA_WIDTH-1; keep at least one bit so the
    // DATA_WIDTH=1 case still elaborates.
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en_q;

    // TX_OUT and Busy are registered, so every branch loads the value the
    // line must carry during the state being entered, not the current one.
    //
    // NOTE: all state here uses non-blocking assignments so every register
    // sees pre-edge values of its peers; blocking would make the result
    // depend on statement order within the block.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: the payload shifter and counter are reset along with the
            // control state so a frame aborted by reset leaves nothing
            // behind; they are small registers, not a memory array.
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                    if (Data_Valid) begin
                        shift_reg <= P_DATA;
                        par_en_q  <= PAR_EN;
                        bit_cnt   <= '0;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        Busy      <= 1'b1;
                    end
                end

                START: begin
                    // Present payload bit 0 and line up bit 1 behind it.
                    state     <= DATA;
                    TX_OUT    <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                    Busy      <= 1'b1;
                end

                DATA: begin
                    Busy <= 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        // The parity slot's register is loaded on the edge
                        // that enters PARITY; the calculator output has been
                        // stable since well before this edge.
                        if (par_en_q) begin
                            state  <= PARITY;
                            TX_OUT <= Par_Bit;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        TX_OUT    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                    end
                end

                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b1;
                end

                STOP: begin
                    // Forces at least one idle cycle between frames.
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end

                // NOTE: the explicit default recovers from unused encodings
                // to a safe idle line instead of holding an undefined state.
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Stimulus pushes the expected serial frame for every request into a queue;
// an independent monitor rebuilds frames from TX_OUT/Busy and compares them.
// Par_Bit is driven by a behavioural parity calculator (even/odd).
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          Par_Bit;
    logic          TX_OUT;
    logic          Busy;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .Par_Bit    (Par_Bit),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] bits;  // bit i = TX_OUT during busy cycle i
        int          len;   // number of Busy=1 cycles
        int          gap;   // idle cycles before the frame, -1 = don't care
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   next_gap = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    endtask

    // Reference frame: start 0, payload LSB first, optional parity, stop 1.
    function automatic void model_frame(input logic [DW-1:0] d, input logic en,
                                        input logic par, output logic [31:0] bits,
                                        output int len);
        bits    = '0;
        bits[0] = 1'b0;
        for (int k = 0; k < DW; k++) bits[1+k] = d[k];
        len = DW + 1;
        if (en) begin
            bits[len] = par;
            len++;
        end
        bits[len] = 1'b1;
        len++;
    endfunction

    // Randomise ignored inputs while a frame is in flight.
    task automatic noise(input bit hold);
        if (hold) begin
            Data_Valid = 1'b1;
            P_DATA     = '1;
        end else begin
            Data_Valid = 1'($urandom_range(0, 1));
            P_DATA     = DW'($urandom);
        end
        PAR_EN = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge inside an idle cycle; the next posedge accepts.
    // Returns at the negedge of the first idle cycle after STOP.
    task automatic send(input logic [DW-1:0] d, input logic en, input logic odd,
                        input logic [31:0] lit_bits, input int lit_len,
                        input bit hold);
        exp_t e;
        logic par;
        par = odd ? ~(^d) : ^d;
        if (lit_len > 0) begin
            e.bits = lit_bits;
            e.len  = lit_len;
        end else begin
            model_frame(d, en, par, e.bits, e.len);
        end
        e.gap      = next_gap;
        P_DATA     = d;
        PAR_EN     = en;
        Data_Valid = 1'b1;
        q.push_back(e);
        @(negedge CLK);
        Par_Bit = par;
        for (int c = 1; c <= e.len; c++) begin
            noise(hold);
            @(negedge CLK);
        end
        Data_Valid = hold;
        next_gap   = 1;
    endtask

    // Monitor: rebuilds frames from the line and scores them.
    initial begin : monitor
        bit          in_frame = 1'b0;
        int          cur_len  = 0;
        int          idle_cnt = 0;
        logic [31:0] cur_bits = '0;
        exp_t        e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (in_frame && q.size() > 0) void'(q.pop_front());
                in_frame = 1'b0;
                idle_cnt = 0;
                cur_len  = 0;
            end else if (Busy) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cur_len  = 0;
                    cur_bits = '0;
                    check("frame_expected", 32'(q.size()), 32'd1);
                    if (q.size() > 0 && q[0].gap >= 0)
                        check("idle_gap", 32'(idle_cnt), 32'(q[0].gap));
                end
                if (cur_len < 32) cur_bits[cur_len] = TX_OUT;
                cur_len++;
            end else begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    check("frame_pending", 32'(q.size() > 0), 32'd1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("frame_len", 32'(cur_len), 32'(e.len));
                        check("frame_bits", cur_bits, e.bits);
                    end
                    idle_cnt = 0;
                end
                idle_cnt++;
                check("idle_tx", 32'(TX_OUT), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [DW-1:0] d;
        logic          en;
        logic          odd;
        int            g;

        RST        = 1'b1;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        Par_Bit    = 1'b0;
        #1 RST = 1'b0;
        #1;
        check("reset_tx", 32'(TX_OUT), 32'd1);
        check("reset_busy", 32'(Busy), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // Directed frames, expected lines taken straight from the
        // documented waveforms. First one also exercises Data_Valid on the
        // first edge after reset release.
        send(8'hA5, 1'b1, 1'b0, 32'h54A, 11, 1'b0);  // even parity
        send(8'h3C, 1'b0, 1'b0, 32'h278, 10, 1'b0);  // no parity
        send(8'h01, 1'b1, 1'b1, 32'h402, 11, 1'b0);  // odd parity

        // Data_Valid held high, P_DATA switches to 0xFF mid-frame.
        send(8'h96, 1'b1, 1'b0, 32'h0, 0, 1'b1);
        send(8'hFF, 1'b1, 1'b1, 32'h0, 0, 1'b0);

        // Reset during payload bit 4 (bit 4 of 0x2A is 0).
        P_DATA     = 8'h2A;
        PAR_EN     = 1'b1;
        Data_Valid = 1'b1;
        q.push_back('{bits: 32'h0, len: 12, gap: next_gap});
        @(posedge CLK);
        #1 Data_Valid = 1'b0;
        repeat (5) @(posedge CLK);
        #1 check("bit4_before_reset", 32'(TX_OUT), 32'd0);
        check("busy_before_reset", 32'(Busy), 32'd1);
        #1 RST = 1'b0;
        #1;
        check("abort_tx", 32'(TX_OUT), 32'd1);
        check("abort_busy", 32'(Busy), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST      = 1'b1;
        next_gap = -1;
        send(8'h55, 1'b0, 1'b0, 32'h0, 0, 1'b0);

        // Randomised frames against the reference model.
        for (int i = 0; i < 1000; i++) begin
            d   = DW'($urandom);
            en  = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            send(d, en, odd, 32'h0, 0, 1'b0);
            g = $urandom_range(0, 3);
            repeat (g) begin
                Data_Valid = 1'b0;
                P_DATA     = DW'($urandom);
                Par_Bit    = 1'($urandom_range(0, 1));
                @(negedge CLK);
                next_gap++;
            end
        end

        Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
